load_store_unit_p: RTL and testbench
====================================

# load_store_unit_p

Parametrised, self-contained load/store unit for the data-memory APB port. Unlike the previous LSU, it:
- handles byte-lane alignment of any byte or halfword address internally;
- generates APB write strobes;
- returns load data in 32/OUT_W beats;
- optionally splits misaligned accesses into two APB transfers.

It sits between the execute stage (start/size/ext/data) and the dmem APB slave.

## Interface
- OUT_W, 16, load-return beat width; legal values 16 or 32; NBEATS = 32/OUT_W.
- ADDR_W, 32, APB address width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  request strobe; accepted only while ready_o=1.
- dir_i  in  1  0=load, 1=store.
- size_i  in  cs_size  SIZE_B / SIZE_H / SIZE_W.
- load_ext_i  in  cs_ext  EXT_Z / EXT_S; applies to loads only.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- ready_o  out  1  unit idle, can accept start_i.
- valid_o  out  1  ldata_o holds a load beat.
- beat_o  out  $clog2(NBEATS)+1  index of the current beat; 0 = low bits.
- done_o  out  1  one-cycle pulse on the final cycle of any request.
- err_o  out  1  one-cycle pulse coincident with done_o when the request failed.
- ldata_o  out  OUT_W  load beat data.
- paddr, psel, penable, pwrite, pwdata[31:0], pstrb[3:0]  out  APB3/4 master signals.
- prdata[31:0], pready, pslverr  in  APB responses.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, DELIVER, RESP.
- **IDLE:**
  - ready_o=1.
  - On start_i, latch dir/size/ext/addr/wdata.
  - If misaligned (H with addr[0]=1, or W with addr[1:0]≠0) and the split feature is absent, go to RESP with the error flag set; otherwise go to SETUP.
- **SETUP:** psel=1, penable=0; lasts one cycle; then ACCESS.
- **ACCESS:** psel=1, penable=1; held until pready=1. On the pready cycle:
  - If pslverr=1 → RESP with error; no load beats.
  - Else if the request is split and this is part 1 → SETUP for part 2.
  - Else load → DELIVER; store → RESP.
- **DELIVER:** NBEATS cycles with valid_o=1. beat_o counts 0..NBEATS-1. done_o=1 on the last beat. Then IDLE.
- **RESP:** one cycle, done_o=1, err_o=error flag; then IDLE.
- **Addressing:**
  - paddr = {addr[ADDR_W-1:2],2'b00} for part 1; part 2 uses paddr+4.
  - pwrite=dir throughout. paddr/pwrite/pwdata/pstrb remain stable from SETUP through the pready cycle.
- **Stores:**
  - Part 1: pwdata = wdata << 8*addr[1:0]; pstrb = (size mask 0001/0011/1111) << addr[1:0], truncated to 4 bits.
  - Part 2: pwdata = wdata >> 8*(4-addr[1:0]); pstrb = the upper spill bits of the mask.
- **Loads:**
  - prdata is captured into a 64-bit buffer {part2, part1}. Result = buffer >> 8*addr[1:0], masked to the size.
  - Zero- or sign-extend to 32 bits per load_ext_i. Beat k = result[OUT_W*k +: OUT_W].
- **Loads, pstrb:** pstrb=0.
- A start_i while ready_o=0 is ignored.

## Timing
- **Reset values:**
  - FSM state=IDLE, so ready_o=1.
  - All other outputs 0: valid_o, beat_o, done_o, err_o, ldata_o, psel, penable, pwrite, paddr, pwdata, pstrb.
  - An asynchronous reset mid-transfer drops psel/penable immediately; the transfer is abandoned.
- **Aligned load, zero wait states** (start accepted in cycle 0): SETUP cycle 1, ACCESS cycle 2, beats in cycles 3..3+NBEATS-1.
- **Aligned store:** RESP/done_o in cycle 3.
- Each pready wait state adds one cycle. A split access adds 2 cycles plus part-2 wait states.
- **Misaligned request, split absent:** RESP in cycle 1; no APB activity.
- ready_o returns in the cycle after done_o. Back-to-back throughput = latency + 1.

## Configuration
- **LSU_MISALIGN_SPLIT_EN defined:** misaligned H/W accesses run as two APB transfers (part 1 at the aligned word, part 2 at +4). A pslverr on either part aborts the request with err_o; part 2 is not issued after a part-1 error.
- **Not defined:** misaligned H/W accesses produce err_o + done_o in RESP with no APB transfer. The split logic and the upper 32 bits of the load buffer are removed.

## Structure
- Package typedefs holds cs_size and cs_ext (existing), plus new lsu_state_e (IDLE, SETUP, ACCESS, DELIVER, RESP).
- One sub-module, lsu_lane_align, holds purely combinational logic:
  - store shift and strobe generation, given addr[1:0], size and part;
  - load extract and extend, given buffer, addr[1:0], size and ext.
- The FSM and buffers live in the top module.

## Test plan
- **Word load, OUT_W=16:** LW at 0x100 with prdata=0xDEADBEEF, pready high → paddr=0x100, pstrb=0; cycle 3 ldata_o=0xBEEF beat 0; cycle 4 ldata_o=0xDEAD beat 1 with done_o.
- **Signed byte load, OUT_W=16:** LB EXT_S at 0x103 with prdata=0x80112233 → beats 0xFF80, 0xFFFF. The same request with EXT_Z → 0x0080, 0x0000.
- **Halfword store:** SH at 0x202 with wdata=0x0000ABCD → pwdata=0xABCD0000, pstrb=1100, pwrite=1; pready delayed 3 cycles → done_o in cycle 6, err_o=0.
- **Misaligned word load, addr 0x101:**
  - Without the macro → no psel; cycle 1 done_o=1, err_o=1.
  - With the macro → paddr 0x100 then 0x104; prdata 0x44332211 then 0x88776655 → result 0x55443322.
- **Slave error:** pslverr=1 on the ACCESS/pready cycle of a LW → err_o and done_o next cycle; valid_o never asserted.
- **Reset mid-transfer:** rst_n low during ACCESS → psel/penable 0 immediately, ready_o=1. After release, a new LW completes normally.

Source files
------------

// File: rtl/load_store_unit_p_pkg.sv
// rtl/load_store_unit_p_pkg.sv - shared types for the data-memory load/store unit
package load_store_unit_p_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } cs_size;

    typedef enum logic {
        EXT_Z = 1'b0,
        EXT_S = 1'b1
    } cs_ext;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        DELIVER,
        RESP
    } lsu_state_e;

    function automatic logic is_misaligned(cs_size size, logic [1:0] addr_lo);
        return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_p_lane_align.sv
// rtl/load_store_unit_p_lane_align.sv - byte-lane steering for store data/strobes and load extract/extend
module lsu_lane_align
    import load_store_unit_p_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  cs_size      size_i,
    input  cs_ext       ext_i,
    input  logic        part_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] buf_i,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    output logic [31:0] ldata_o
);

    logic [3:0]  mask;
    logic [7:0]  strb8;
    logic [63:0] wide_w;
    logic [31:0] raw;

    always_comb begin
        case (size_i)
            SIZE_B:  mask = 4'b0001;
            SIZE_H:  mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        // Shift into a two-word window; the upper word is what spills into part 2.
        strb8    = {4'b0000, mask} << addr_lo_i;
        wide_w   = {32'b0, wdata_i} << {addr_lo_i, 3'b000};
        pwdata_o = part_i ? wide_w[63:32] : wide_w[31:0];
        pstrb_o  = part_i ? strb8[7:4] : strb8[3:0];

        raw = buf_i[{addr_lo_i, 3'b000} +: 32];
        case (size_i)
            SIZE_B:  ldata_o = {{24{(ext_i == EXT_S) && raw[7]}}, raw[7:0]};
            SIZE_H:  ldata_o = {{16{(ext_i == EXT_S) && raw[15]}}, raw[15:0]};
            default: ldata_o = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit_p.sv
// rtl/load_store_unit_p.sv - APB load/store unit; LSU_MISALIGN_SPLIT_EN enables two-transfer misaligned access
module load_store_unit_p
    import load_store_unit_p_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 32,
    parameter int NBEATS = 32 / OUT_W,
    parameter int BW     = $clog2(NBEATS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              dir_i,
    input  cs_size            size_i,
    input  cs_ext             load_ext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [BW-1:0]     beat_o,
    output logic              done_o,
    output logic              err_o,
    output logic [OUT_W-1:0]  ldata_o,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    output logic [3:0]        pstrb,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    lsu_state_e        state_q, state_d;
    logic              dir_q;
    cs_size            size_q;
    cs_ext             ext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [BW-1:0]     beat_q;
    logic [63:0]       buf_full;
    logic              part;
    logic              more_parts;
    logic              mis;
    logic              last_beat;
    logic              apb_active;
    logic [31:0]       al_pwdata;
    logic [3:0]        al_pstrb;
    logic [31:0]       lresult;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        part_q;
    logic        split_q;
    logic [63:0] buf_q;
    assign part       = part_q;
    assign more_parts = split_q && !part_q;
    assign buf_full   = buf_q;
`else
    logic [31:0] buf_q;
    assign part       = 1'b0;
    assign more_parts = 1'b0;
    assign buf_full   = {32'b0, buf_q};
`endif

    assign mis       = is_misaligned(size_i, addr_i[1:0]);
    assign last_beat = (beat_q == BW'(NBEATS - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d = SETUP;
`else
                    state_d = mis ? RESP : SETUP;
`endif
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    if (pslverr)         state_d = RESP;
                    else if (more_parts) state_d = SETUP;
                    else if (dir_q)      state_d = RESP;
                    else                 state_d = DELIVER;
                end
            end
            DELIVER: if (last_beat) state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            size_q  <= SIZE_B;
            ext_q   <= EXT_Z;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            buf_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            part_q  <= 1'b0;
            split_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        dir_q   <= dir_i;
                        size_q  <= size_i;
                        ext_q   <= load_ext_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        beat_q  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        err_q   <= 1'b0;
                        part_q  <= 1'b0;
                        split_q <= mis;
`else
                        err_q   <= mis;
`endif
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        if (pslverr) err_q <= 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (part_q) buf_q[63:32] <= prdata;
                        else        buf_q[31:0]  <= prdata;
                        if (more_parts && !pslverr) part_q <= 1'b1;
`else
                        buf_q <= prdata;
`endif
                    end
                end
                DELIVER: beat_q <= beat_q + 1'b1;
                default: ;
            endcase
        end
    end

    lsu_lane_align u_align (
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .ext_i     (ext_q),
        .part_i    (part),
        .wdata_i   (wdata_q),
        .buf_i     (buf_full),
        .pwdata_o  (al_pwdata),
        .pstrb_o   (al_pstrb),
        .ldata_o   (lresult)
    );

    // APB outputs are decoded from state so an async reset drops psel/penable at once.
    assign apb_active = (state_q == SETUP) || (state_q == ACCESS);
    assign psel       = apb_active;
    assign penable    = (state_q == ACCESS);
    assign pwrite     = apb_active && dir_q;
    assign paddr      = apb_active ? ({addr_q[ADDR_W-1:2], 2'b00} + (part ? ADDR_W'(4) : ADDR_W'(0))) : '0;
    assign pwdata     = (apb_active && dir_q) ? al_pwdata : '0;
    assign pstrb      = (apb_active && dir_q) ? al_pstrb : '0;

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DELIVER);
    assign beat_o  = valid_o ? beat_q : '0;
    assign done_o  = (valid_o && last_beat) || (state_q == RESP);
    assign err_o   = (state_q == RESP) && err_q;
    assign ldata_o = valid_o ? lresult[OUT_W*beat_q +: OUT_W] : '0;

endmodule

// File: tb/tb_load_store_unit_p.sv
// tb/tb_load_store_unit_p.sv - directed self-checking bench for load_store_unit_p
module tb_load_store_unit_p;
    import load_store_unit_p_pkg::*;

    localparam int OUT_W = 16;
    localparam int BW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i, dir_i;
    cs_size           size_i;
    cs_ext            load_ext_i;
    logic [31:0]      addr_i, wdata_i;
    logic             ready_o, valid_o, done_o, err_o;
    logic [BW-1:0]    beat_o;
    logic [OUT_W-1:0] ldata_o;
    logic [31:0]      paddr, pwdata, prdata;
    logic             psel, penable, pwrite, pready, pslverr;
    logic [3:0]       pstrb;

    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_data [2];
    int          wcnt = 0;
    int          xfer_n = 0;
    logic        psel_seen = 1'b0;
    logic [31:0] seen_addr [2];
    logic [31:0] seen_wdata [2];
    logic [3:0]  seen_strb [2];
    logic        seen_write [2];

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cyc, nvalid, b0_cyc;
    logic        err_seen, rdy_after;
    logic [15:0] b0, b1;

    always #5 clk = ~clk;

    load_store_unit_p #(.OUT_W(OUT_W), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .dir_i(dir_i), .size_i(size_i),
        .load_ext_i(load_ext_i), .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o),
        .valid_o(valid_o), .beat_o(beat_o), .done_o(done_o), .err_o(err_o), .ldata_o(ldata_o),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    assign pready  = psel && penable && (wcnt >= slv_wait);
    assign pslverr = pready && slv_err;
    assign prdata  = slv_data[xfer_n[0]];

    always @(posedge clk) begin
        if (start_i && ready_o) begin
            xfer_n    <= 0;
            psel_seen <= 1'b0;
        end else begin
            if (psel) psel_seen <= 1'b1;
            if (pready) begin
                seen_addr[xfer_n[0]]  <= paddr;
                seen_wdata[xfer_n[0]] <= pwdata;
                seen_strb[xfer_n[0]]  <= pstrb;
                seen_write[xfer_n[0]] <= pwrite;
                xfer_n <= xfer_n + 1;
            end
        end
        wcnt <= (penable && !pready) ? wcnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic d, input cs_size s, input cs_ext e,
                           input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        dir_i = d; size_i = s; load_ext_i = e; addr_i = a; wdata_i = w; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        done_cyc = -1; err_seen = 1'b0; nvalid = 0; b0 = '0; b1 = '0; b0_cyc = -1;
        for (int n = 1; n <= 60 && done_cyc < 0; n++) begin
            @(negedge clk);
            if (valid_o) begin
                nvalid++;
                if (beat_o == 0) begin b0 = ldata_o; b0_cyc = n; end
                else b1 = ldata_o;
            end
            if (done_o) begin done_cyc = n; err_seen = err_o; end
        end
        check("done_seen", {31'b0, done_cyc >= 0}, 32'd1);
        @(negedge clk);
        rdy_after = ready_o;
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; dir_i = 1'b0; size_i = SIZE_B; load_ext_i = EXT_Z;
        addr_i = '0; wdata_i = '0; slv_data[0] = '0; slv_data[1] = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_psel", {31'b0, psel}, 32'd0);
        check("rst_penable", {31'b0, penable}, 32'd0);
        check("rst_pwrite", {31'b0, pwrite}, 32'd0);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_beat", {30'b0, beat_o}, 32'd0);
        check("rst_ldata", {16'b0, ldata_o}, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_pstrb", {28'b0, pstrb}, 32'd0);
        rst_n = 1'b1;

        slv_data[0] = 32'hDEADBEEF;
        run_req(1'b0, SIZE_W, EXT_Z, 32'h100, 32'h0);
        check("lw_paddr", seen_addr[0], 32'h100);
        check("lw_pstrb", {28'b0, seen_strb[0]}, 32'd0);
        check("lw_pwrite", {31'b0, seen_write[0]}, 32'd0);
        check("lw_beat0", {16'b0, b0}, 32'hBEEF);
        check("lw_beat0_cyc", b0_cyc, 32'd3);
        check("lw_beat1", {16'b0, b1}, 32'hDEAD);
        check("lw_done_cyc", done_cyc, 32'd4);
        check("lw_err", {31'b0, err_seen}, 32'd0);
        check("lw_nvalid", nvalid, 32'd2);
        check("lw_ready_after", {31'b0, rdy_after}, 32'd1);

        slv_data[0] = 32'h80112233;
        run_req(1'b0, SIZE_B, EXT_S, 32'h103, 32'h0);
        check("lbs_beat0", {16'b0, b0}, 32'hFF80);
        check("lbs_beat1", {16'b0, b1}, 32'hFFFF);
        run_req(1'b0, SIZE_B, EXT_Z, 32'h103, 32'h0);
        check("lbz_beat0", {16'b0, b0}, 32'h0080);
        check("lbz_beat1", {16'b0, b1}, 32'h0000);

        slv_wait = 3;
        run_req(1'b1, SIZE_H, EXT_Z, 32'h202, 32'h0000ABCD);
        check("sh_paddr", seen_addr[0], 32'h200);
        check("sh_pwdata", seen_wdata[0], 32'hABCD0000);
        check("sh_pstrb", {28'b0, seen_strb[0]}, 32'hC);
        check("sh_pwrite", {31'b0, seen_write[0]}, 32'd1);
        check("sh_done_cyc", done_cyc, 32'd6);
        check("sh_err", {31'b0, err_seen}, 32'd0);
        check("sh_nvalid", nvalid, 32'd0);
        slv_wait = 0;

        run_req(1'b1, SIZE_B, EXT_Z, 32'h101, 32'hFFFFFF5A);
        check("sb_pwdata", seen_wdata[0], 32'hFFFF5A00);
        check("sb_pstrb", {28'b0, seen_strb[0]}, 32'h2);
        check("sb_done_cyc", done_cyc, 32'd3);

        slv_data[0] = 32'h44332211;
        slv_data[1] = 32'h88776655;
        run_req(1'b0, SIZE_W, EXT_Z, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("mis_paddr1", seen_addr[0], 32'h100);
        check("mis_paddr2", seen_addr[1], 32'h104);
        check("mis_beat0", {16'b0, b0}, 32'h3322);
        check("mis_beat1", {16'b0, b1}, 32'h5544);
        check("mis_done_cyc", done_cyc, 32'd6);
        check("mis_err", {31'b0, err_seen}, 32'd0);
`else
        check("mis_psel", {31'b0, psel_seen}, 32'd0);
        check("mis_done_cyc", done_cyc, 32'd1);
        check("mis_err", {31'b0, err_seen}, 32'd1);
        check("mis_nvalid", nvalid, 32'd0);
`endif

        slv_err = 1'b1;
        slv_data[0] = 32'hDEADBEEF;
        run_req(1'b0, SIZE_W, EXT_Z, 32'h100, 32'h0);
        check("slverr_done_cyc", done_cyc, 32'd3);
        check("slverr_err", {31'b0, err_seen}, 32'd1);
        check("slverr_nvalid", nvalid, 32'd0);
        slv_err = 1'b0;

        slv_wait = 20;
        @(negedge clk);
        dir_i = 1'b0; size_i = SIZE_W; load_ext_i = EXT_Z; addr_i = 32'h300; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_penable_before", {31'b0, penable}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_psel", {31'b0, psel}, 32'd0);
        check("rst_mid_penable", {31'b0, penable}, 32'd0);
        check("rst_mid_ready", {31'b0, ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        slv_wait = 0;

        slv_data[0] = 32'h12345678;
        run_req(1'b0, SIZE_W, EXT_Z, 32'h300, 32'h0);
        check("post_rst_paddr", seen_addr[0], 32'h300);
        check("post_rst_beat0", {16'b0, b0}, 32'h5678);
        check("post_rst_beat1", {16'b0, b1}, 32'h1234);
        check("post_rst_done_cyc", done_cyc, 32'd4);
        check("post_rst_err", {31'b0, err_seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
